fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 119 +++++++++++
 tb/tb_fifo_rd_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry skid
// buffer, with IDLE/RUN/DRAIN control, a delivered-word counter and a sticky underflow flag.
module fifo_rd_stream #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic                  rd_en,
   input  logic [FIFO_WIDTH-1:0] data_out,
   input  logic                  empty,
   input  logic                  underflow,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  word_cnt,
   output logic                  err_underflow
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_occ;
   logic                  r_inflight;
   logic [FIFO_WIDTH-1:0] r_buf0;
   logic [FIFO_WIDTH-1:0] r_buf1;
   logic [CNT_WIDTH-1:0]  r_word_cnt;
   logic                  r_err;

   logic                  w_pop;
   logic [1:0]            w_occ_nxt;
   logic [2:0]            w_level;
   logic                  w_rd_en;

   // Level counts buffered words plus the one in flight, net of this cycle's pop,
   // so a read is only issued when its returning word is guaranteed a slot.
   always_comb begin
      w_pop     = (r_occ != 2'd0) && m_ready;
      w_occ_nxt = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_rd_en   = (r_state == ST_RUN) && !empty && (w_level < 3'd2);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!enable) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (enable)
               w_state_nxt = ST_RUN;
            else if (!r_inflight && (w_occ_nxt == 2'd0))
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_inflight <= 1'b0;
         r_occ      <= 2'd0;
         r_word_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_rd_en;
         r_occ      <= w_occ_nxt;
         if (w_pop)     r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
         if (underflow) r_err      <= 1'b1;
      end
   end

   // Head is r_buf0; a pop shifts r_buf1 forward, and the returning word lands
   // in whichever slot becomes the tail after that shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf0 <= '0;
         r_buf1 <= '0;
      end else if (r_inflight) begin
         if (w_pop) begin
            if (r_occ == 2'd2) begin
               r_buf0 <= r_buf1;
               r_buf1 <= data_out;
            end else begin
               r_buf0 <= data_out;
            end
         end else if (r_occ == 2'd0) begin
            r_buf0 <= data_out;
         end else begin
            r_buf1 <= data_out;
         end
      end else if (w_pop) begin
         r_buf0 <= r_buf1;
      end
   end

   always_comb begin
      rd_en         = w_rd_en;
      m_data        = r_buf0;
      m_valid       = (r_occ != 2'd0);
      busy          = (r_state != ST_IDLE);
      word_cnt      = r_word_cnt;
      err_underflow = r_err;
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural synchronous FIFO, scoreboard of loaded
// words checked on every pop, table-driven stream runs plus hand corner cases.
module tb_fifo_rd_stream;

   localparam int unsigned FW = 16;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          rd_en;
   logic [FW-1:0] data_out;
   logic          empty;
   logic          underflow;
   logic [FW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          busy;
   logic [CW-1:0] word_cnt;
   logic          err_underflow;

   fifo_rd_stream #(.FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rd_en(rd_en),
      .data_out(data_out), .empty(empty), .underflow(underflow),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
      .word_cnt(word_cnt), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   logic [FW-1:0] fifo_q[$];
   logic [FW-1:0] sb_q[$];
   assign empty = (fifo_q.size() == 0);

   int unsigned   n_checks = 0;
   int unsigned   n_errors = 0;
   logic [CW-1:0] exp_cnt;
   logic          hold_prev;
   logic [FW-1:0] hold_data;
   int            cyc;
   int            rd_pulses;
   int            first_rd;
   int            first_v;
   bit            vlog[512];

   typedef struct {
      int unsigned   n_words;
      logic [7:0]    rdy_pat;
      logic [CW-1:0] exp_cnt;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      logic          s_rd;
      logic          s_pop;
      logic [FW-1:0] e;
      #1;
      s_rd  = rd_en;
      s_pop = m_valid & m_ready;
      if (hold_prev)
         check(m_valid && (m_data == hold_data), "hold_stable", {15'd0, m_valid, m_data}, {16'd1, hold_data});
      hold_prev = m_valid & ~m_ready;
      hold_data = m_data;
      if (s_rd) check(!empty, "rd_on_empty", 32'(empty), 32'd0);
      check(word_cnt == exp_cnt, "word_cnt", 32'(word_cnt), 32'(exp_cnt));
      if (s_pop) begin
         check(sb_q.size() != 0, "extra_word", 32'(m_data), 32'd0);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(m_data == e, "m_data", 32'(m_data), 32'(e));
         end
      end
      if (s_rd) begin
         rd_pulses++;
         if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (cyc < 512) vlog[cyc] = m_valid;
      cyc++;
      @(posedge clk);
      #1;
      if (s_rd && fifo_q.size() != 0) data_out = fifo_q.pop_front();
      if (s_pop) exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      enable    = 1'b0;
      m_ready   = 1'b0;
      underflow = 1'b0;
      rst_n     = 1'b0;
      #1;
      check(m_valid == 1'b0, "rst_m_valid", 32'(m_valid), 32'd0);
      check(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
      check(word_cnt == '0, "rst_word_cnt", 32'(word_cnt), 32'd0);
      check(rd_en == 1'b0, "rst_rd_en", 32'(rd_en), 32'd0);
      check(m_data == '0, "rst_m_data", 32'(m_data), 32'd0);
      check(err_underflow == 1'b0, "rst_err", 32'(err_underflow), 32'd0);
      fifo_q.delete();
      sb_q.delete();
      exp_cnt   = '0;
      hold_prev = 1'b0;
      data_out  = '0;
      rd_pulses = 0;
      first_rd  = -1;
      first_v   = -1;
      cyc       = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load(input int unsigned n, input logic [FW-1:0] base);
      for (int unsigned i = 0; i < n; i++) begin
         fifo_q.push_back(base + FW'(i));
         sb_q.push_back(base + FW'(i));
      end
   endtask

   task automatic run_out(input int unsigned limit);
      for (int unsigned c = 0; c < limit && sb_q.size() != 0; c++) tick();
      check(sb_q.size() == 0, "drain_timeout", sb_q.size(), 32'd0);
   endtask

   initial begin
      int unsigned base_cnt;
      int unsigned nv;

      vecs[0] = '{n_words: 8,  rdy_pat: 8'hFF, exp_cnt: 4'd8};
      vecs[1] = '{n_words: 4,  rdy_pat: 8'h0F, exp_cnt: 4'd4};
      vecs[2] = '{n_words: 5,  rdy_pat: 8'hAA, exp_cnt: 4'd5};
      vecs[3] = '{n_words: 17, rdy_pat: 8'hFF, exp_cnt: 4'd1};
      vecs[4] = '{n_words: 3,  rdy_pat: 8'h01, exp_cnt: 4'd3};

      rst_n = 1'b1; enable = 1'b0; m_ready = 1'b0; underflow = 1'b0; data_out = '0;
      exp_cnt = '0; hold_prev = 1'b0; hold_data = '0;
      @(negedge clk);

      // Table-driven stream runs with cyclic ready patterns
      for (int r = 0; r < 5; r++) begin
         do_reset();
         load(vecs[r].n_words, FW'(16'h0100 * (r + 1)));
         enable = 1'b1;
         for (int c = 0; c < 300 && sb_q.size() != 0; c++) begin
            m_ready = vecs[r].rdy_pat[c % 8];
            tick();
         end
         check(sb_q.size() == 0, "row_drain", sb_q.size(), 32'd0);
         check(word_cnt == vecs[r].exp_cnt, "row_word_cnt", 32'(word_cnt), 32'(vecs[r].exp_cnt));
         enable = 1'b0; m_ready = 1'b1;
         for (int c = 0; c < 10 && busy; c++) tick();
         check(busy == 1'b0, "row_idle", 32'(busy), 32'd0);
      end

      // Streaming latency and throughput
      do_reset();
      load(8, 16'h0001);
      enable = 1'b1; m_ready = 1'b1;
      run_out(40);
      check((first_rd >= 0) && (first_v - first_rd == 2), "latency", 32'(first_v - first_rd), 32'd2);
      nv = 0;
      for (int k = 0; k < 8; k++) if (first_v >= 0 && vlog[first_v + k]) nv++;
      check(nv == 8, "consecutive_valid", nv, 32'd8);
      check(word_cnt == 4'd8, "stream_cnt", 32'(word_cnt), 32'd8);
      tick();
      check(!rd_en && busy, "rd_drop_empty", {rd_en, busy}, 32'd1);

      // Backpressure: 5+ stalled cycles with 4 words queued
      do_reset();
      load(4, 16'h0A00);
      enable = 1'b1; m_ready = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check(rd_pulses == 2, "bp_rd_pulses", rd_pulses, 32'd2);
      check(m_valid && m_data == 16'h0A00, "bp_head", {15'd0, m_valid, m_data}, {16'd1, 16'h0A00});
      m_ready = 1'b1;
      run_out(20);
      check(word_cnt == 4'd4, "bp_cnt", 32'(word_cnt), 32'd4);

      // Drain with one word buffered and one in flight
      do_reset();
      load(4, 16'h0B00);
      enable = 1'b1; m_ready = 1'b0;
      tick(); tick(); tick();
      enable = 1'b0;
      #1 check(rd_en == 1'b0, "drain_rd_first", 32'(rd_en), 32'd0);
      tick();
      m_ready  = 1'b1;
      base_cnt = exp_cnt;
      for (int c = 0; c < 10 && busy; c++) begin
         #1 check(rd_en == 1'b0, "drain_rd", 32'(rd_en), 32'd0);
         tick();
      end
      check(4'(exp_cnt - base_cnt) == 4'd2, "drain_words", 32'(4'(exp_cnt - base_cnt)), 32'd2);
      check(busy == 1'b0, "drain_idle", 32'(busy), 32'd0);

      // Reset mid-stream with a full buffer, then no reads before enable
      do_reset();
      load(4, 16'h0C00);
      enable = 1'b1; m_ready = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      check(m_valid == 1'b1, "pre_rst_valid", 32'(m_valid), 32'd1);
      do_reset();
      load(2, 16'h0D00);
      for (int c = 0; c < 4; c++) tick();
      check(rd_pulses == 0, "no_rd_before_en", rd_pulses, 32'd0);
      enable = 1'b1; m_ready = 1'b1;
      run_out(20);
      check(word_cnt == 4'd2, "post_rst_cnt", 32'(word_cnt), 32'd2);

      // Sticky underflow
      underflow = 1'b1;
      tick();
      underflow = 1'b0;
      check(err_underflow == 1'b1, "err_set", 32'(err_underflow), 32'd1);
      for (int c = 0; c < 3; c++) tick();
      check(err_underflow == 1'b1, "err_sticky", 32'(err_underflow), 32'd1);
      do_reset();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
